// File: rtl/voice_scheduler.sv
// voice_scheduler: polyphony controller between the keypad GPIO bank and the
// oscillator voices. Scans one key per cycle, detects press/release edges,
// allocates presses to a fixed voice pool (stealing the oldest voice when the
// pool is full) and drives registered note/active/retrigger outputs.
module voice_scheduler #(
  parameter int unsigned NUM_KEYS   = 13,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = 4,
  parameter int unsigned AGE_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         all_off,
  input  logic [NUM_KEYS-1:0]          keys,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NOTE_W-1:0]            scan_idx
);

  localparam logic [NOTE_W-1:0] LAST_KEY = NOTE_W'(NUM_KEYS - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

  // Scan position and per-key previous level
  logic [NOTE_W-1:0]   scan_q, scan_d;
  logic [NUM_KEYS-1:0] key_prev_q, key_prev_d;

  // Per-voice state
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;

  // Edge detection for the key currently under scan
  logic key_now;
  logic key_was;
  logic press;
  logic release_edge;

  // Allocation target selection
  logic                  free_found;
  int unsigned           free_sel;
  int unsigned           oldest_sel;
  logic [AGE_W-1:0]      oldest_age;
  logic [NUM_VOICES-1:0] target_oh;

  // Evaluate the scanned key: an edge only counts on an enabled cycle
  always_comb begin
    key_now      = keys[scan_q];
    key_was      = key_prev_q[scan_q];
    press        = en & key_now & ~key_was;
    release_edge = en & ~key_now & key_was;
  end

  // Pick the lowest inactive voice, else the oldest voice (lowest index on ties)
  always_comb begin
    free_found = 1'b0;
    free_sel   = 0;
    oldest_sel = 0;
    oldest_age = age_q[0];
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!free_found && !active_q[v]) begin
        free_found = 1'b1;
        free_sel   = v;
      end
    end
    for (int unsigned v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > oldest_age) begin
        oldest_age = age_q[v];
        oldest_sel = v;
      end
    end
    target_oh = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      target_oh[v] = free_found ? (v == free_sel) : (v == oldest_sel);
    end
  end

  // Next-state: scan advance, then panic, press allocation or release
  always_comb begin
    scan_d     = scan_q;
    key_prev_d = key_prev_q;
    note_d     = note_q;
    age_d      = age_q;
    active_d   = active_q;
    trig_d     = '0;

    if (en) begin
      key_prev_d[scan_q] = key_now;
      scan_d = (scan_q == LAST_KEY) ? '0 : scan_q + 1'b1;
    end

    // Panic wins over any edge evaluated in the same cycle; clearing the
    // previous levels makes still-held keys re-trigger on their next scan.
    if (all_off) begin
      active_d   = '0;
      key_prev_d = '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        age_d[v] = '0;
      end
    end else if (press) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (target_oh[v]) begin
          note_d[v]   = scan_q;
          active_d[v] = 1'b1;
          age_d[v]    = '0;
          trig_d[v]   = 1'b1;
        end else if (active_q[v] && (age_q[v] != AGE_MAX)) begin
          age_d[v] = age_q[v] + 1'b1;
        end
      end
    end else if (release_edge) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (active_q[v] && (note_q[v] == scan_q)) begin
          active_d[v] = 1'b0;
          age_d[v]    = '0;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q     <= '0;
      key_prev_q <= '0;
      note_q     <= '{default: '0};
      age_q      <= '{default: '0};
      active_q   <= '0;
      trig_q     <= '0;
    end else begin
      scan_q     <= scan_d;
      key_prev_q <= key_prev_d;
      note_q     <= note_d;
      age_q      <= age_d;
      active_q   <= active_d;
      trig_q     <= trig_d;
    end
  end

  // Pack per-voice notes onto the flat output bus
  always_comb begin
    voice_note = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
    end
  end

  assign voice_active = active_q;
  assign voice_trig   = trig_q;
  assign scan_idx     = scan_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed testbench for voice_scheduler with hand-computed expectations.
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        all_off;
  logic [12:0] keys;
  logic [15:0] voice_note;
  logic [3:0]  voice_active;
  logic [3:0]  voice_trig;
  logic [3:0]  scan_idx;

  int checks   = 0;
  int failures = 0;

  voice_scheduler #(
    .NUM_KEYS  (13),
    .NUM_VOICES(4),
    .NOTE_W    (4),
    .AGE_W     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .all_off     (all_off),
    .keys        (keys),
    .voice_note  (voice_note),
    .voice_active(voice_active),
    .voice_trig  (voice_trig),
    .scan_idx    (scan_idx)
  );

  always #5 clk = ~clk;

  // Bounded wait until the given key is the next to be scanned
  task automatic wait_scan(input logic [3:0] k);
    int n;
    n = 0;
    while (scan_idx !== k && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (scan_idx !== k) begin
      failures++;
      $display("FAIL wait_scan timeout: scan_idx=%0d required=%0d", scan_idx, k);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_scan;
    rst = 1'b1; en = 1'b1; all_off = 1'b0; keys = 13'h1FFF;
    repeat (2) @(negedge clk);
    checks++; if (voice_active !== 4'b0000) begin failures++; $display("FAIL reset_active: got=%b exp=0000", voice_active); end
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL reset_trig: got=%b exp=0000", voice_trig); end
    checks++; if (scan_idx !== 4'd0) begin failures++; $display("FAIL reset_scan: got=%0d exp=0", scan_idx); end
    checks++; if (voice_note !== 16'h0000) begin failures++; $display("FAIL reset_note: got=%h exp=0000", voice_note); end
    rst = 1'b0; keys = '0;
    for (int i = 0; i < 14; i++) begin
      exp_scan = 4'(i % 13);
      checks++; if (scan_idx !== exp_scan) begin failures++; $display("FAIL scan_seq[%0d]: got=%0d exp=%0d", i, scan_idx, exp_scan); end
      checks++; if (voice_active !== 4'b0000) begin failures++; $display("FAIL idle_active[%0d]: got=%b exp=0000", i, voice_active); end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    keys = 13'h0020;
    wait_scan(4'd5);
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL single_trig: got=%b exp=0001", voice_trig); end
    checks++; if (voice_active !== 4'b0001) begin failures++; $display("FAIL single_active: got=%b exp=0001", voice_active); end
    checks++; if (voice_note[3:0] !== 4'd5) begin failures++; $display("FAIL single_note: got=%0d exp=5", voice_note[3:0]); end
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL single_trig_end: got=%b exp=0000", voice_trig); end
    checks++; if (voice_active !== 4'b0001) begin failures++; $display("FAIL single_hold: got=%b exp=0001", voice_active); end
    keys = '0;
    wait_scan(4'd5);
    checks++; if (voice_active !== 4'b0001) begin failures++; $display("FAIL release_early: got=%b exp=0001", voice_active); end
    @(negedge clk);
    checks++; if (voice_active !== 4'b0000) begin failures++; $display("FAIL release_active: got=%b exp=0000", voice_active); end
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL release_trig: got=%b exp=0000", voice_trig); end
    checks++; if (voice_note[3:0] !== 4'd5) begin failures++; $display("FAIL release_note: got=%0d exp=5", voice_note[3:0]); end
  endtask

  task automatic test_fill();
    int         ks [4];
    logic [3:0] exp_trig;
    logic [3:0] exp_act;
    logic [3:0] exp_note;
    ks = '{1, 3, 7, 9};
    wait_scan(4'd0);
    keys = 13'h028A;
    for (int j = 0; j < 4; j++) begin
      wait_scan(4'(ks[j]));
      @(negedge clk);
      exp_trig = 4'(1 << j);
      exp_act  = 4'((1 << (j + 1)) - 1);
      exp_note = 4'(ks[j]);
      checks++; if (voice_trig !== exp_trig) begin failures++; $display("FAIL fill_trig[%0d]: got=%b exp=%b", j, voice_trig, exp_trig); end
      checks++; if (voice_active !== exp_act) begin failures++; $display("FAIL fill_active[%0d]: got=%b exp=%b", j, voice_active, exp_act); end
      checks++; if (voice_note[j*4 +: 4] !== exp_note) begin failures++; $display("FAIL fill_note[%0d]: got=%0d exp=%0d", j, voice_note[j*4 +: 4], exp_note); end
    end
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL fill_trig_end: got=%b exp=0000", voice_trig); end
    checks++; if (voice_note !== 16'h9731) begin failures++; $display("FAIL fill_notes: got=%h exp=9731", voice_note); end
  endtask

  task automatic test_steal();
    keys = keys | 13'h0800;
    wait_scan(4'd11);
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL steal1_trig: got=%b exp=0001", voice_trig); end
    checks++; if (voice_active !== 4'b1111) begin failures++; $display("FAIL steal1_active: got=%b exp=1111", voice_active); end
    checks++; if (voice_note !== 16'h973B) begin failures++; $display("FAIL steal1_notes: got=%h exp=973B", voice_note); end
    keys = keys | 13'h1000;
    wait_scan(4'd12);
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0010) begin failures++; $display("FAIL steal2_trig: got=%b exp=0010", voice_trig); end
    checks++; if (voice_note !== 16'h97CB) begin failures++; $display("FAIL steal2_notes: got=%h exp=97CB", voice_note); end
    keys = keys & ~13'h0002;
    wait_scan(4'd1);
    @(negedge clk);
    checks++; if (voice_active !== 4'b1111) begin failures++; $display("FAIL stolen_release_active: got=%b exp=1111", voice_active); end
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL stolen_release_trig: got=%b exp=0000", voice_trig); end
    checks++; if (voice_note !== 16'h97CB) begin failures++; $display("FAIL stolen_release_notes: got=%h exp=97CB", voice_note); end
    keys = keys & ~13'h0080;
    wait_scan(4'd7);
    @(negedge clk);
    checks++; if (voice_active !== 4'b1011) begin failures++; $display("FAIL release7_active: got=%b exp=1011", voice_active); end
    checks++; if (voice_note !== 16'h97CB) begin failures++; $display("FAIL release7_notes: got=%h exp=97CB", voice_note); end
  endtask

  task automatic test_panic();
    int ntrig;
    keys = 13'h1A01;
    wait_scan(4'd0);
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0100) begin failures++; $display("FAIL refill_trig: got=%b exp=0100", voice_trig); end
    checks++; if (voice_note !== 16'h90CB) begin failures++; $display("FAIL refill_notes: got=%h exp=90CB", voice_note); end
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    checks++; if (voice_active !== 4'b0000) begin failures++; $display("FAIL panic_active: got=%b exp=0000", voice_active); end
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL panic_trig: got=%b exp=0000", voice_trig); end
    checks++; if (scan_idx !== 4'd2) begin failures++; $display("FAIL panic_scan: got=%0d exp=2", scan_idx); end
    ntrig = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++; if (!$onehot0(voice_trig)) begin failures++; $display("FAIL trig_onehot[%0d]: got=%b exp=onehot0", i, voice_trig); end
      if (voice_trig != 4'b0000) ntrig++;
    end
    checks++; if (ntrig !== 4) begin failures++; $display("FAIL panic_realloc_count: got=%0d exp=4", ntrig); end
    checks++; if (voice_active !== 4'b1111) begin failures++; $display("FAIL panic_realloc_active: got=%b exp=1111", voice_active); end
    checks++; if (voice_note !== 16'h0CB9) begin failures++; $display("FAIL panic_realloc_notes: got=%h exp=0CB9", voice_note); end
    en = 1'b0; all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    checks++; if (voice_active !== 4'b0000) begin failures++; $display("FAIL panic_noen_active: got=%b exp=0000", voice_active); end
    checks++; if (scan_idx !== 4'd2) begin failures++; $display("FAIL panic_noen_scan: got=%0d exp=2", scan_idx); end
    en = 1'b1;
  endtask

  task automatic test_priority();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; keys = 13'h0010;
    wait_scan(4'd4);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    checks++; if (voice_active !== 4'b0000) begin failures++; $display("FAIL prio_active: got=%b exp=0000", voice_active); end
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL prio_trig: got=%b exp=0000", voice_trig); end
    wait_scan(4'd4);
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL prio_redetect_trig: got=%b exp=0001", voice_trig); end
    checks++; if (voice_note[3:0] !== 4'd4) begin failures++; $display("FAIL prio_redetect_note: got=%0d exp=4", voice_note[3:0]); end
  endtask

  task automatic test_freeze();
    rst = 1'b1; keys = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_scan(4'd2);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      keys[2] = ~keys[2];
      @(negedge clk);
      checks++; if (scan_idx !== 4'd2) begin failures++; $display("FAIL freeze_scan[%0d]: got=%0d exp=2", i, scan_idx); end
      checks++; if (voice_active !== 4'b0000 || voice_trig !== 4'b0000) begin failures++; $display("FAIL freeze_out[%0d]: got act=%b trig=%b exp=0000", i, voice_active, voice_trig); end
    end
    keys = 13'h0004; en = 1'b1;
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL unfreeze_trig: got=%b exp=0001", voice_trig); end
    checks++; if (voice_note[3:0] !== 4'd2) begin failures++; $display("FAIL unfreeze_note: got=%0d exp=2", voice_note[3:0]); end
  endtask

  task automatic test_reset_mid();
    keys = 13'h0020; rst = 1'b1;
    @(negedge clk);
    checks++; if (voice_active !== 4'b0000 || voice_trig !== 4'b0000) begin failures++; $display("FAIL midreset_out: got act=%b trig=%b exp=0000", voice_active, voice_trig); end
    checks++; if (scan_idx !== 4'd0 || voice_note !== 16'h0000) begin failures++; $display("FAIL midreset_state: got scan=%0d note=%h exp=0/0000", scan_idx, voice_note); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (voice_trig !== 4'b0000) begin failures++; $display("FAIL midreset_trig_after: got=%b exp=0000", voice_trig); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_steal();
    test_panic();
    test_priority();
    test_freeze();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
